mssd_param_demux: RTL and testbench

//  Parametrised serial-to-multichannel demultiplexer. The serial frame is: start, header (port, length), payload, stop.

---
 rtl/mssd_param_demux.sv | 136 +++++++++++++
 tb/tb_mssd_param_demux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mssd_param_demux.sv
// Serial-to-multichannel demultiplexer: start, header (port, length), payload, stop.
// Define MSSD_PARITY_EN to add an even-parity bit (PAR state) between payload and stop.
module mssd_param_demux #(
  parameter int PN_W  = 2,
  parameter int LEN_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SerIn,
  output logic [PN_W-1:0]      pn,
  output logic [2**PN_W-1:0]   p,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 frame_ok,
  output logic                 error
);

  localparam int NCH  = 2**PN_W;
  localparam int HW   = PN_W + LEN_W;
  localparam int HC_W = $clog2(HW + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    STOP = 3'd3,
    ERR  = 3'd4
`ifdef MSSD_PARITY_EN
    , PAR = 3'd5
`endif
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [HW-2:0]      r_hdr;
  logic [HC_W-1:0]    r_hcnt;
  logic [LEN_W-1:0]   r_dcnt;
  logic [PN_W-1:0]    r_pn;
  logic [HW-1:0]      w_hdrNext;
  logic [LEN_W-1:0]   w_lenCap;
  logic               w_hdrLast;
`ifdef MSSD_PARITY_EN
  logic               r_par;
`endif

  // Header arrives LSB first, so new bits enter at the top and the port field ends up at the bottom.
  assign w_hdrNext = {SerIn, r_hdr};
  assign w_lenCap  = w_hdrNext[HW-1:PN_W];
  assign w_hdrLast = (r_hcnt == HC_W'(HW - 1));
  assign pn        = r_pn;

  always_comb begin
    w_stateNext = r_state;
    out_valid   = 1'b0;
    frame_ok    = 1'b0;
    error       = 1'b0;
    busy        = (r_state != IDLE) && (r_state != ERR);
    case (r_state)
      IDLE: if (!SerIn) w_stateNext = HDR;
      HDR: begin
        if (w_hdrLast) begin
          if (w_lenCap != '0) w_stateNext = DATA;
`ifdef MSSD_PARITY_EN
          else w_stateNext = PAR;
`else
          else w_stateNext = STOP;
`endif
        end
      end
      DATA: begin
        out_valid = 1'b1;
`ifdef MSSD_PARITY_EN
        if (r_dcnt == LEN_W'(1)) w_stateNext = PAR;
`else
        if (r_dcnt == LEN_W'(1)) w_stateNext = STOP;
`endif
      end
`ifdef MSSD_PARITY_EN
      PAR: w_stateNext = (r_par ^ SerIn) ? ERR : STOP;
`endif
      STOP: begin
        frame_ok    = SerIn;
        w_stateNext = SerIn ? IDLE : ERR;
      end
      ERR: begin
        error = 1'b1;
        if (SerIn) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
    p = out_valid ? (NCH'(SerIn) << r_pn) : '0;
  end

  // Counters are reloaded on entry to their state rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hdr   <= '0;
      r_hcnt  <= '0;
      r_dcnt  <= '0;
      r_pn    <= '0;
`ifdef MSSD_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        IDLE: begin
          r_hcnt <= '0;
`ifdef MSSD_PARITY_EN
          r_par  <= 1'b0;
`endif
        end
        HDR: begin
          r_hdr  <= w_hdrNext[HW-1:1];
          r_hcnt <= r_hcnt + HC_W'(1);
`ifdef MSSD_PARITY_EN
          r_par  <= r_par ^ SerIn;
`endif
          if (w_hdrLast) begin
            r_pn   <= w_hdrNext[PN_W-1:0];
            r_dcnt <= w_lenCap;
          end
        end
        DATA: begin
          r_dcnt <= r_dcnt - LEN_W'(1);
`ifdef MSSD_PARITY_EN
          r_par  <= r_par ^ SerIn;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mssd_param_demux.sv
// Scoreboard bench for mssd_param_demux (PN_W=2, LEN_W=6); follows MSSD_PARITY_EN if defined.
module tb_mssd_param_demux;

  localparam int PN_W  = 2;
  localparam int LEN_W = 6;
  localparam int NCH   = 2**PN_W;

  typedef struct {
    logic [PN_W-1:0] pnExp;
    logic [NCH-1:0]  pExp;
  } expT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             SerIn = 1'b1;
  logic [PN_W-1:0]  pn;
  logic [NCH-1:0]   p;
  logic             out_valid, busy, frame_ok, error;

  expT sbQueue[$];
  int  checksTotal = 0;
  int  checksPassed = 0;
  int  cycleCount = 0;
  int  validCount = 0;
  int  frameOkCount = 0;
  int  lastFrameOkCycle = -1;
  int  stopCycle = 0;

  mssd_param_demux #(.PN_W(PN_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .SerIn(SerIn), .pn(pn), .p(p),
    .out_valid(out_valid), .busy(busy), .frame_ok(frame_ok), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checksTotal++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    else
      checksPassed++;
  endtask

  // Monitor samples mid-cycle; every payload bit must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        validCount++;
        if (sbQueue.size() == 0) checkOutput("unexpectedValid", 1, 0);
        else begin
          expT e;
          e = sbQueue.pop_front();
          checkOutput("pRoute", p, e.pExp);
          checkOutput("pnDuringData", pn, e.pnExp);
        end
      end else begin
        checkOutput("pIdleZero", p, 0);
      end
      if (frame_ok) begin
        frameOkCount++;
        lastFrameOkCycle = cycleCount;
      end
    end
  end

  task automatic applyStimulus(input logic b);
    SerIn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic sendHeader(input logic [PN_W-1:0] pnVal, input logic [LEN_W-1:0] lenVal);
    applyStimulus(1'b0);
    checkOutput("busyAfterStart", busy, 1);
    for (int i = 0; i < PN_W; i++) applyStimulus(pnVal[i]);
    for (int i = 0; i < LEN_W; i++) applyStimulus(lenVal[i]);
  endtask

  task automatic sendFrame(input logic [PN_W-1:0] pnVal, input logic [LEN_W-1:0] lenVal,
                           input logic [63:0] data, input logic stopBit, input logic parFlip);
    logic parBit;
    expT  e;
    parBit = (^pnVal) ^ (^lenVal);
    sendHeader(pnVal, lenVal);
    for (int i = 0; i < int'(lenVal); i++) begin
      e.pnExp = pnVal;
      e.pExp  = NCH'(data[i]) << pnVal;
      sbQueue.push_back(e);
      parBit = parBit ^ data[i];
      applyStimulus(data[i]);
    end
`ifdef MSSD_PARITY_EN
    applyStimulus(parBit ^ parFlip);
    checkOutput("parityError", error, parFlip);
`endif
    SerIn = stopBit;
    stopCycle = cycleCount;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int okBefore, validBefore;
    #1;
    checkOutput("rstPn", pn, 0);
    checkOutput("rstP", p, 0);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstFrameOk", frame_ok, 0);
    checkOutput("rstError", error, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) applyStimulus(1'b1);

    // Basic frame: pn=2, len=3, data 1,0,1.
    okBefore = frameOkCount; validBefore = validCount;
    sendFrame(2'd2, 6'd3, 64'b101, 1'b1, 1'b0);
    checkOutput("f1FrameOk", frameOkCount - okBefore, 1);
    checkOutput("f1OkCycle", lastFrameOkCycle, stopCycle);
    checkOutput("f1Valid", validCount - validBefore, 3);
    checkOutput("f1Pn", pn, 2);
    checkOutput("f1Error", error, 0);
    checkOutput("f1Busy", busy, 0);
    checkOutput("f1SbEmpty", sbQueue.size(), 0);

    // Zero-length frame still needs its stop bit.
    okBefore = frameOkCount; validBefore = validCount;
    sendFrame(2'd0, 6'd0, 64'd0, 1'b1, 1'b0);
    checkOutput("f2FrameOk", frameOkCount - okBefore, 1);
    checkOutput("f2OkCycle", lastFrameOkCycle, stopCycle);
    checkOutput("f2Valid", validCount - validBefore, 0);
    checkOutput("f2Pn", pn, 0);
    checkOutput("f2Busy", busy, 0);

    // Bad stop bit parks in ERR until the line returns high.
    okBefore = frameOkCount;
    sendFrame(2'd3, 6'd2, 64'b11, 1'b0, 1'b0);
    checkOutput("f3ErrorNext", error, 1);
    checkOutput("f3BusyErr", busy, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0);
      checkOutput("f3ErrorHeld", error, 1);
    end
    applyStimulus(1'b1);
    checkOutput("f3ErrorClear", error, 0);
    checkOutput("f3FrameOk", frameOkCount - okBefore, 0);
    checkOutput("f3Pn", pn, 3);
    checkOutput("f3SbEmpty", sbQueue.size(), 0);

    // Reset during the second payload bit of a len=5 frame.
    begin
      expT e;
      okBefore = frameOkCount;
      sendHeader(2'd3, 6'd5);
      e.pnExp = 2'd3; e.pExp = NCH'(1) << 3;
      sbQueue.push_back(e);
      applyStimulus(1'b1);
      SerIn = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("r4Valid", out_valid, 0);
      checkOutput("r4P", p, 0);
      checkOutput("r4Busy", busy, 0);
      checkOutput("r4Pn", pn, 0);
      checkOutput("r4Error", error, 0);
      checkOutput("r4FrameOk", frame_ok, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) applyStimulus(1'b1);
      checkOutput("r4NoFrameOk", frameOkCount - okBefore, 0);
      validBefore = validCount;
      sendFrame(2'd1, 6'd4, 64'b1011, 1'b1, 1'b0);
      checkOutput("r4CleanOk", frameOkCount - okBefore, 1);
      checkOutput("r4CleanValid", validCount - validBefore, 4);
      checkOutput("r4CleanPn", pn, 1);
      checkOutput("r4SbEmpty", sbQueue.size(), 0);
    end

    // Maximum length payload.
    okBefore = frameOkCount; validBefore = validCount;
    sendFrame(2'd1, 6'd63, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    checkOutput("f5Valid", validCount - validBefore, 63);
    checkOutput("f5FrameOk", frameOkCount - okBefore, 1);
    checkOutput("f5SbEmpty", sbQueue.size(), 0);

`ifdef MSSD_PARITY_EN
    okBefore = frameOkCount;
    sendFrame(2'd1, 6'd2, 64'b01, 1'b1, 1'b0);
    checkOutput("f6ParOk", frameOkCount - okBefore, 1);
    okBefore = frameOkCount;
    sendFrame(2'd1, 6'd2, 64'b01, 1'b1, 1'b1);
    checkOutput("f6ParBad", frameOkCount - okBefore, 0);
`endif

    repeat (2) applyStimulus(1'b1);
    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
